// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL bit positions and the default window base address.
package mmio_pkg;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hF0;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_MASK    = 2;
    localparam int CTRL_BITS        = 3;

    // The window is four words, so only the upper six address bits select it.
    function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
        return addr[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/mmio_countdown.sv
// Countdown core: decrement, reload, direct load and the sticky expiry flag.
// Requests an ENABLE clear when a one-shot count expires.
module mmio_countdown #(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             auto_reload_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             count_wr_i,
    input  logic [WIDTH-1:0] count_wdata_i,
    input  logic             status_clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             expired_o,
    output logic             disable_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             expire;

    assign expire    = enable_i && (count_q == '0);
    assign disable_o = expire && !auto_reload_i;

    // A CPU write to COUNT overrides the step; a fresh expiry overrides a W1C clear.
    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        if (enable_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (auto_reload_i) begin
                count_d = load_value_i;
            end
        end
        if (count_wr_i) begin
            count_d = count_wdata_i;
        end
        if (status_clr_i) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = expired_q;

endmodule

// File: rtl/mmio_timer_responder.sv
// Bus responder for the four-word timer window: decode, CTRL/LOAD storage and
// registered read mux. Define MMIO_IRQ_EN to add the level interrupt output.
module mmio_timer_responder
    import mmio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int         DATA_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            MAR,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  Mem_CS,
    input  logic                  Mem_EN,
    output logic                  mmio_hit
`ifdef MMIO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic                  hit, wr, rd_any, rd_hit;
    logic [1:0]            off;
    logic [CTRL_BITS-1:0]  ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  mmio_hit_q, mmio_hit_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] count;
    logic                  expired;
    logic                  disable_req;

    assign off    = MAR[1:0];
    assign hit    = Mem_CS && in_window(MAR, BASE_ADDR);
    assign wr     = hit && Mem_EN;
    assign rd_any = Mem_CS && !Mem_EN;
    assign rd_hit = hit && !Mem_EN;

    mmio_countdown #(
        .WIDTH(DATA_WIDTH)
    ) u_countdown (
        .clock         (clock),
        .reset         (reset),
        .enable_i      (ctrl_q[CTRL_ENABLE]),
        .auto_reload_i (ctrl_q[CTRL_AUTO_RELOAD]),
        .load_value_i  (load_q),
        .count_wr_i    (wr && (off == OFF_COUNT)),
        .count_wdata_i (data_in),
        .status_clr_i  (wr && (off == OFF_STATUS) && data_in[0]),
        .count_o       (count),
        .expired_o     (expired),
        .disable_o     (disable_req)
    );

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata[CTRL_BITS-1:0] = ctrl_q;
            OFF_LOAD:   rdata = load_q;
            OFF_COUNT:  rdata = count;
            OFF_STATUS: rdata[0] = expired;
            default:    rdata = '0;
        endcase
    end

    // A CPU write to CTRL wins over the one-shot ENABLE clear on the same edge.
    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        data_out_d = data_out_q;
        mmio_hit_d = mmio_hit_q;
        if (disable_req) begin
            ctrl_d[CTRL_ENABLE] = 1'b0;
        end
        if (wr && (off == OFF_CTRL)) begin
            ctrl_d = data_in[CTRL_BITS-1:0];
        end
        if (wr && (off == OFF_LOAD)) begin
            load_d = data_in;
        end
        if (rd_hit) begin
            data_out_d = rdata;
        end
        if (rd_any) begin
            mmio_hit_d = rd_hit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            data_out_q <= '0;
            mmio_hit_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            data_out_q <= data_out_d;
            mmio_hit_q <= mmio_hit_d;
        end
    end

    assign data_out = data_out_q;
    assign mmio_hit = mmio_hit_q;

`ifdef MMIO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= expired && ctrl_q[CTRL_IRQ_MASK];
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Scoreboard bench for mmio_timer_responder: reads push hand-computed
// responses, a bus monitor pops and compares after each sampled read.
module tb_mmio_timer_responder;

    localparam int DW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    MAR;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          Mem_CS;
    logic          Mem_EN;
    logic          mmio_hit;
`ifdef MMIO_IRQ_EN
    logic          irq;
`endif

    int checks   = 0;
    int failures = 0;

    logic          expHitQ[$];
    logic [DW-1:0] expDataQ[$];
    string         nameQ[$];

    logic          monHit;
    logic [DW-1:0] monData;
    string         monName;

    mmio_timer_responder dut (
        .clock    (clock),
        .reset    (reset),
        .MAR      (MAR),
        .data_in  (data_in),
        .data_out (data_out),
        .Mem_CS   (Mem_CS),
        .Mem_EN   (Mem_EN),
        .mmio_hit (mmio_hit)
`ifdef MMIO_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic en, input logic [7:0] addr,
                                 input logic [DW-1:0] wdata, input logic expHit,
                                 input logic [DW-1:0] expData, input string name);
        @(negedge clock);
        Mem_CS  = cs;
        Mem_EN  = en;
        MAR     = addr;
        data_in = wdata;
        if (cs && !en) begin
            expHitQ.push_back(expHit);
            expDataQ.push_back(expData);
            nameQ.push_back(name);
        end
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [DW-1:0] wdata);
        applyStimulus(1'b1, 1'b1, addr, wdata, 1'b0, '0, "write");
    endtask

    task automatic readReg(input logic [7:0] addr, input logic expHit,
                           input logic [DW-1:0] expData, input string name);
        applyStimulus(1'b1, 1'b0, addr, '0, expHit, expData, name);
    endtask

    task automatic busIdle();
        applyStimulus(1'b0, 1'b0, 8'h00, '0, 1'b0, '0, "idle");
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 8 && expHitQ.size() != 0; i++) begin
            @(posedge clock);
        end
        #2;
        if (expHitQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d responses still pending, expected 0", expHitQ.size());
            expHitQ.delete();
            expDataQ.delete();
            nameQ.delete();
        end
    endtask

`ifdef MMIO_IRQ_EN
    task automatic idleCheckIrq(input logic expIrq, input string name);
        busIdle();
        @(posedge clock);
        #1;
        checkOutput(name, DW'(irq), DW'(expIrq));
    endtask
`endif

    // Bus monitor: every read sampled on a posedge owes one response.
    always @(posedge clock) begin
        if (!reset && Mem_CS && !Mem_EN) begin
            #1;
            if (expHitQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_read: got data %h hit %b, expected no read",
                         data_out, mmio_hit);
            end else begin
                monHit  = expHitQ.pop_front();
                monData = expDataQ.pop_front();
                monName = nameQ.pop_front();
                checkOutput({monName, "_hit"}, DW'(mmio_hit), DW'(monHit));
                checkOutput({monName, "_data"}, data_out, monData);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        Mem_CS  = 1'b0;
        Mem_EN  = 1'b0;
        MAR     = 8'h00;
        data_in = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset_data_out", data_out, '0);
        checkOutput("reset_mmio_hit", DW'(mmio_hit), '0);
        reset = 1'b0;

        // Reset while counting
        writeReg(8'hF2, 24'd5);
        writeReg(8'hF0, 24'd1);
        readReg(8'hF2, 1'b1, 24'd5, "pre_reset_count");
        busIdle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_data_out", data_out, '0);
        checkOutput("async_reset_mmio_hit", DW'(mmio_hit), '0);
`ifdef MMIO_IRQ_EN
        checkOutput("async_reset_irq", DW'(irq), '0);
`endif
        @(negedge clock);
        reset = 1'b0;
        readReg(8'hF0, 1'b1, 24'd0, "post_reset_ctrl");
        readReg(8'hF2, 1'b1, 24'd0, "post_reset_count");
        readReg(8'hF3, 1'b1, 24'd0, "post_reset_status");

        // One-shot
        writeReg(8'hF1, 24'd3);
        writeReg(8'hF2, 24'd3);
        writeReg(8'hF0, 24'd1);
        readReg(8'hF2, 1'b1, 24'd3, "oneshot_count3");
        readReg(8'hF2, 1'b1, 24'd2, "oneshot_count2");
        readReg(8'hF2, 1'b1, 24'd1, "oneshot_count1");
        readReg(8'hF2, 1'b1, 24'd0, "oneshot_count0");
        readReg(8'hF3, 1'b1, 24'd1, "oneshot_expired");
        readReg(8'hF0, 1'b1, 24'd0, "oneshot_ctrl_cleared");

        // Auto-reload
        writeReg(8'hF3, 24'd1);
        writeReg(8'hF1, 24'd2);
        writeReg(8'hF2, 24'd0);
        writeReg(8'hF0, 24'd3);
        readReg(8'hF3, 1'b1, 24'd0, "reload_status_before");
        readReg(8'hF2, 1'b1, 24'd2, "reload_count2");
        readReg(8'hF2, 1'b1, 24'd1, "reload_count1");
        readReg(8'hF2, 1'b1, 24'd0, "reload_count0");
        readReg(8'hF2, 1'b1, 24'd2, "reload_count2_again");
        readReg(8'hF3, 1'b1, 24'd1, "reload_expired");
        writeReg(8'hF0, 24'd0);
        readReg(8'hF2, 1'b1, 24'd2, "reload_stopped_count");

        // W1C racing a fresh expiry
        writeReg(8'hF3, 24'd1);
        writeReg(8'hF2, 24'd1);
        writeReg(8'hF0, 24'd1);
        readReg(8'hF3, 1'b1, 24'd0, "race_status_before");
        writeReg(8'hF3, 24'd1);
        readReg(8'hF3, 1'b1, 24'd1, "race_expiry_wins");
        writeReg(8'hF3, 24'd1);
        readReg(8'hF3, 1'b1, 24'd0, "race_second_clear");
        readReg(8'hF0, 1'b1, 24'd0, "race_ctrl_cleared");

        // Decode and reserved CTRL bits
        writeReg(8'hF1, 24'hABCDEF);
        readReg(8'hF1, 1'b1, 24'hABCDEF, "decode_load");
        readReg(8'hEF, 1'b0, 24'hABCDEF, "decode_below");
        readReg(8'hF4, 1'b0, 24'hABCDEF, "decode_above");
        writeReg(8'hF5, 24'h000007);
        applyStimulus(1'b0, 1'b1, 8'hF1, 24'h123456, 1'b0, '0, "no_cs_write");
        readReg(8'hF1, 1'b1, 24'hABCDEF, "decode_load_unchanged");
        readReg(8'hF0, 1'b1, 24'd0, "decode_ctrl_unchanged");
        writeReg(8'hF0, 24'hFFFFF4);
        readReg(8'hF0, 1'b1, 24'h000004, "ctrl_reserved_bits");
        writeReg(8'hF0, 24'd0);
        busIdle();
        drainQueue();

`ifdef MMIO_IRQ_EN
        writeReg(8'hF3, 24'd1);
        writeReg(8'hF2, 24'd1);
        writeReg(8'hF0, 24'd5);
        idleCheckIrq(1'b0, "irq_counting");
        idleCheckIrq(1'b0, "irq_expiry_edge");
        idleCheckIrq(1'b1, "irq_rises");
        writeReg(8'hF3, 24'd1);
        @(posedge clock);
        #1;
        checkOutput("irq_clear_edge", DW'(irq), DW'(1'b1));
        idleCheckIrq(1'b0, "irq_falls");
`endif

        busIdle();
        drainQueue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
